switch_port_arbiter: RTL and testbench

Output-port arbiter for the 4-port switch. Each input port presents a packet request with a 4-bit target mask. The arbiter grants an input exclusive ownership of all its target output ports for the length of one packet, and it honours per-output suspend. Arbitration is round-robin over inputs, and packets with disjoint target sets may be in flight at the same time. It sits between the input-port header decoders and the output-port muxes, and drives their select lines.

---
 rtl/switch_port_arbiter_if.sv | 34 +++
 rtl/switch_port_arbiter.sv | 107 ++++++++++
 tb/tb_switch_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/switch_port_arbiter_if.sv
// switch_port_arbiter_if
// Bundles the request/release/suspend inputs and the grant/ownership outputs
// exchanged between the input-port header decoders (master side) and the
// output-port arbiter (slave side).
//   req        : per-input packet-header-ready flags
//   req_target : per-input 4-bit target masks, input i on [4i+3:4i]
//   done       : per-input end-of-packet pulse
//   suspend    : per-output "do not start a new packet"
//   grant      : per-input ownership level
//   out_busy   : per-output owned flag
//   out_src    : per-output 2-bit owner index, output j on [2j+1:2j]
//   bad_req    : per-input illegal-request pulse
interface switch_port_arbiter_if #(
  parameter int NPORTS = 4
);
  logic [NPORTS-1:0]        req;
  logic [NPORTS*NPORTS-1:0] req_target;
  logic [NPORTS-1:0]        done;
  logic [NPORTS-1:0]        suspend;
  logic [NPORTS-1:0]        grant;
  logic [NPORTS-1:0]        out_busy;
  logic [2*NPORTS-1:0]      out_src;
  logic [NPORTS-1:0]        bad_req;

  modport master (
    output req, req_target, done, suspend,
    input  grant, out_busy, out_src, bad_req
  );

  modport slave (
    input  req, req_target, done, suspend,
    output grant, out_busy, out_src, bad_req
  );
endinterface

// File: rtl/switch_port_arbiter.sv
// switch_port_arbiter
// Round-robin output-port arbiter for the 4-port switch. An input is granted
// exclusive ownership of every output in its target mask for one packet;
// inputs with disjoint targets may own outputs concurrently. At most one new
// grant is issued per cycle. All outputs are registered.
//   clk   : switch clock
//   reset : synchronous active-high reset
//   bus   : switch_port_arbiter_if slave modport (see interface header)
module switch_port_arbiter #(
  parameter int NPORTS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  switch_port_arbiter_if.slave  bus
);

  logic [3:0] grant_reg, grant_next;
  logic [3:0] busy_reg, busy_next;
  logic [3:0] bad_reg, bad_next;
  logic [7:0] src_reg, src_next;
  logic [1:0] rr_reg, rr_next;

  logic [3:0] tgt [4];
  logic [3:0] legal;
  logic [3:0] pending;
  logic [3:0] eligible;
  logic [3:0] release_vec;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [3:0] win_tgt;

  genvar gi;

  // Per-input classification. A request is "pending" only while it is not
  // already granted and not in its bad_req cycle, so a held req is masked.
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
      assign tgt[gi]         = bus.req_target[4*gi +: 4];
      assign legal[gi]       = (tgt[gi] != 4'h0) &&
                               ((tgt[gi] == 4'hf) || !tgt[gi][gi]);
      assign pending[gi]     = bus.req[gi] & ~grant_reg[gi] & ~bad_reg[gi];
      assign eligible[gi]    = pending[gi] & legal[gi] &
                               ~(|(tgt[gi] & (busy_reg | bus.suspend)));
      assign release_vec[gi] = bus.done[gi] & grant_reg[gi];
    end
  endgenerate

  // Round-robin pick: walk the offsets from farthest to nearest so the
  // last assignment left standing is the first eligible input after rr_reg.
  always_comb begin
    logic [1:0] idx;
    win_valid = 1'b0;
    win_idx   = rr_reg;
    idx       = rr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_reg + 2'(k);
      if (eligible[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_tgt = tgt[win_idx];

  // Per-output ownership. A winner can never target an output being released
  // in the same cycle because eligibility excludes currently busy outputs.
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      logic own_rel;
      logic take;
      assign own_rel = busy_reg[gi] & release_vec[src_reg[2*gi +: 2]];
      assign take    = win_valid & win_tgt[gi];
      assign busy_next[gi] = take | (busy_reg[gi] & ~own_rel);
      assign src_next[2*gi +: 2] = take    ? win_idx :
                                   own_rel ? 2'd0    : src_reg[2*gi +: 2];
    end
  endgenerate

  assign grant_next = (grant_reg & ~release_vec) |
                      (win_valid ? (4'b0001 << win_idx) : 4'b0000);
  assign bad_next   = pending & ~legal;
  assign rr_next    = win_valid ? (win_idx + 2'd1) : rr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_reg <= 4'h0;
      busy_reg  <= 4'h0;
      bad_reg   <= 4'h0;
      src_reg   <= 8'h00;
      rr_reg    <= 2'd0;
    end else begin
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      bad_reg   <= bad_next;
      src_reg   <= src_next;
      rr_reg    <= rr_next;
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.out_busy = busy_reg;
  assign bus.out_src  = src_reg;
  assign bus.bad_req  = bad_reg;

endmodule

// File: tb/tb_switch_port_arbiter.sv
module tb_switch_port_arbiter;

  logic clk;
  logic reset;

  switch_port_arbiter_if bus ();

  switch_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] b;
    logic [7:0] s;
    logic [3:0] bad;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, record the expected
  // registered outputs, then compare just after the rising edge.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] r,
                     input logic [15:0] t, input logic [3:0] d,
                     input logic [3:0] s, input logic [3:0] eg,
                     input logic [3:0] eb, input logic [7:0] es,
                     input logic [3:0] ebad);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.req        = r;
    bus.req_target = t;
    bus.done       = d;
    bus.suspend    = s;
    exp_q.push_back('{g: eg, b: eb, s: es, bad: ebad});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("%-14s grant=%b busy=%b src=%h bad=%b", tag, bus.grant,
             bus.out_busy, bus.out_src, bus.bad_req);
    check_val({tag, ".grant"},    32'(bus.grant),    32'(e.g));
    check_val({tag, ".out_busy"}, 32'(bus.out_busy), 32'(e.b));
    check_val({tag, ".out_src"},  32'(bus.out_src),  32'(e.s));
    check_val({tag, ".bad_req"},  32'(bus.bad_req),  32'(e.bad));
  endtask

  initial begin
    reset          = 1'b1;
    bus.req        = 4'h0;
    bus.req_target = 16'h0;
    bus.done       = 4'h0;
    bus.suspend    = 4'h0;

    //   tag            rst req      target    done     susp     grant    busy     src    bad
    cyc("reset0",       1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("reset1",       1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    // done with nothing granted is ignored
    cyc("stray_done",   0, 4'b0000, 16'h0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // single grant: input 2 -> output 0, then release
    cyc("single_gnt",   0, 4'b0100, 16'h0100, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 8'h02, 4'b0000);
    cyc("single_rel",   0, 4'b0100, 16'h0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("single_idle",  0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // conflict: rr_ptr back to 0, inputs 0 and 3 both want output 1
    cyc("rst_rr",       1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("conf_gnt0",    0, 4'b1001, 16'h2002, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 8'h00, 4'b0000);
    cyc("conf_rel0",    0, 4'b1000, 16'h2002, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("conf_gnt3",    0, 4'b1000, 16'h2002, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 8'h0c, 4'b0000);
    cyc("conf_rel3",    0, 4'b0000, 16'h0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // parallel disjoint grants (rr_ptr=0)
    cyc("par_gnt0",     0, 4'b0011, 16'h0084, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 8'h00, 4'b0000);
    cyc("par_gnt1",     0, 4'b0010, 16'h0084, 4'b0000, 4'b0000, 4'b0011, 4'b1100, 8'h40, 4'b0000);
    cyc("par_rel1",     0, 4'b0000, 16'h0004, 4'b0010, 4'b0000, 4'b0001, 4'b0100, 8'h00, 4'b0000);

    // broadcast from input 1 waits while input 0 owns output 2
    cyc("bc_wait",      0, 4'b0010, 16'h00f4, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 8'h00, 4'b0000);
    cyc("bc_rel0",      0, 4'b0010, 16'h00f4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("bc_gnt",       0, 4'b0010, 16'h00f0, 4'b0000, 4'b0000, 4'b0010, 4'b1111, 8'h55, 4'b0000);
    cyc("bc_rel",       0, 4'b0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // suspend on output 3 holds off input 2
    cyc("susp_hold0",   0, 4'b0100, 16'h0800, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("susp_hold1",   0, 4'b0100, 16'h0800, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("susp_drop",    0, 4'b0100, 16'h0800, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 8'h80, 4'b0000);
    cyc("susp_reassert",0, 4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'b0100, 4'b1000, 8'h80, 4'b0000);
    cyc("susp_rel",     0, 4'b0000, 16'h0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // illegal: empty mask on input 0, self-target on input 1
    cyc("bad_pulse",    0, 4'b0011, 16'h0030, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0011);
    cyc("bad_masked",   0, 4'b0011, 16'h0030, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("bad_idle",     0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    // two packets granted (rr_ptr=3 so input 3 first), then reset mid-packet
    cyc("two_gnt3",     0, 4'b1001, 16'h4002, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 8'h30, 4'b0000);
    cyc("two_gnt0",     0, 4'b0001, 16'h4002, 4'b0000, 4'b0000, 4'b1001, 4'b0110, 8'h30, 4'b0000);
    cyc("mid_reset",    1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
    cyc("post_reset",   0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
